pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register for the fetch-to-decode boundary and any later stage boundary. It carries PC and instruction with a valid bit and supports stall (hold), flush (bubble injection) and a configurable number of start-up bubbles after reset. Saturating stall and flush event counters provide hazard-performance visibility. Sits between the fetch unit and the decoder; stall and flush are driven by the hazard unit.

---
 rtl/pipe_stage_reg.sv | 58 +++++
 tb/tb_pipe_stage_reg.sv | 114 +++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: PC/instruction stage register with stall, flush, boot bubbles and hazard counters
module pipe_stage_reg #(
  parameter int PC_W = 32,
  parameter int INST_W = 32,
  parameter logic [INST_W-1:0] NOP_INST = 32'h00000013,
  parameter int BOOT_BUBBLES = 1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  input  logic              clr_cnt,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              boot_busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  logic [3:0] boot_cnt;
  assign boot_busy = boot_cnt != 4'd0;
  assign in_ready = rst_n & ~boot_busy & ~stall & ~flush;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pc <= '0;
      out_inst <= NOP_INST;
      boot_cnt <= 4'(BOOT_BUBBLES);
    end else if (boot_busy) begin
      out_valid <= 1'b0;
      out_pc <= '0;
      out_inst <= NOP_INST;
      boot_cnt <= boot_cnt - 4'd1;
    end else if (flush) begin
      out_valid <= 1'b0;
      out_inst <= NOP_INST;
    end else if (!stall) begin
      out_valid <= in_valid;
      out_pc <= in_pc;
      out_inst <= in_valid ? in_inst : NOP_INST;
    end
  end
  // Hazard events during the boot phase are not counted
  always_ff @(posedge clk) begin
    if (!rst_n || clr_cnt) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!boot_busy) begin
      if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      if (stall && !flush && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed scoreboard bench for pipe_stage_reg
module tb_pipe_stage_reg;
  localparam logic [31:0] NOP = 32'h00000013;
  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, stall, flush, clr_cnt, out_valid, boot_busy;
  logic [31:0] in_pc, in_inst, out_pc, out_inst;
  logic [3:0] stall_cnt, flush_cnt;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  pipe_stage_reg #(.PC_W(32), .INST_W(32), .NOP_INST(NOP), .BOOT_BUBBLES(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
    .in_ready(in_ready), .stall(stall), .flush(flush), .clr_cnt(clr_cnt),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .boot_busy(boot_busy),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst,
                     input logic st, input logic fl, input logic clr, input logic rdy,
                     input logic ev, input logic [31:0] epc, input logic [31:0] einst);
    exp_t e;
    in_valid = v;
    in_pc = pc;
    in_inst = inst;
    stall = st;
    flush = fl;
    clr_cnt = clr;
    q.push_back('{v: ev, pc: epc, inst: einst});
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e.v));
    chk({tag, ".out_pc"}, out_pc, e.pc);
    chk({tag, ".out_inst"}, out_inst, e.inst);
  endtask
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_pc = '0;
    in_inst = '0;
    stall = 1'b0;
    flush = 1'b0;
    clr_cnt = 1'b0;
    cyc("rst0", 1'b1, 32'h40, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, NOP);
    cyc("rst1", 1'b1, 32'h44, 32'h22, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, NOP);
    chk("rst.boot_busy", 32'(boot_busy), 32'd1);
    chk("rst.stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst.flush_cnt", 32'(flush_cnt), 32'd0);
    rst_n = 1'b1;
    cyc("boot1", 1'b1, 32'h0, 32'h00500093, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, NOP);
    chk("boot1.boot_busy", 32'(boot_busy), 32'd1);
    // stall and flush during boot must be ignored and not counted
    cyc("boot2", 1'b1, 32'h0, 32'h00500093, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, NOP);
    chk("boot2.boot_busy", 32'(boot_busy), 32'd0);
    chk("boot2.stall_cnt", 32'(stall_cnt), 32'd0);
    chk("boot2.flush_cnt", 32'(flush_cnt), 32'd0);
    cyc("load0", 1'b1, 32'h0, 32'h00500093, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h00500093);
    cyc("load4", 1'b1, 32'h4, 32'h00a00113, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h4, 32'h00a00113);
    cyc("load8", 1'b1, 32'h8, 32'h002081b3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8, 32'h002081b3);
    cyc("stall1", 1'b1, 32'hc, 32'h40208233, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h002081b3);
    cyc("stall2", 1'b1, 32'hc, 32'h40208233, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8, 32'h002081b3);
    chk("stall.stall_cnt", 32'(stall_cnt), 32'd2);
    chk("stall.flush_cnt", 32'(flush_cnt), 32'd0);
    cyc("loadc", 1'b1, 32'hc, 32'h40208233, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hc, 32'h40208233);
    cyc("load10", 1'b1, 32'h10, 32'h00112023, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h10, 32'h00112023);
    cyc("flst", 1'b1, 32'h14, 32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, NOP);
    chk("flst.flush_cnt", 32'(flush_cnt), 32'd1);
    chk("flst.stall_cnt", 32'(stall_cnt), 32'd2);
    cyc("inv", 1'b0, 32'h14, 32'hdeadbeef, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h14, NOP);
    cyc("fl2", 1'b1, 32'h18, 32'h00000073, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h14, NOP);
    chk("fl2.flush_cnt", 32'(flush_cnt), 32'd2);
    for (int i = 0; i < 20; i++)
      cyc("sat", 1'b1, 32'h18, 32'h00000073, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h14, NOP);
    chk("sat.stall_cnt", 32'(stall_cnt), 32'd15);
    chk("sat.flush_cnt", 32'(flush_cnt), 32'd2);
    cyc("clr", 1'b1, 32'h18, 32'h00000073, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h14, NOP);
    chk("clr.stall_cnt", 32'(stall_cnt), 32'd0);
    chk("clr.flush_cnt", 32'(flush_cnt), 32'd0);
    cyc("load20", 1'b1, 32'h20, 32'h00c00093, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 32'h00c00093);
    cyc("fl3", 1'b1, 32'h24, 32'h00c00093, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h20, NOP);
    cyc("load24", 1'b1, 32'h24, 32'h00d00093, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h24, 32'h00d00093);
    rst_n = 1'b0;
    cyc("mrst", 1'b1, 32'h28, 32'h00e00093, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, NOP);
    chk("mrst.boot_busy", 32'(boot_busy), 32'd1);
    chk("mrst.flush_cnt", 32'(flush_cnt), 32'd0);
    rst_n = 1'b1;
    cyc("reboot1", 1'b1, 32'h28, 32'h00e00093, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, NOP);
    chk("reboot1.boot_busy", 32'(boot_busy), 32'd1);
    cyc("reboot2", 1'b1, 32'h28, 32'h00e00093, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, NOP);
    chk("reboot2.boot_busy", 32'(boot_busy), 32'd0);
    cyc("load28", 1'b1, 32'h28, 32'h00e00093, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h28, 32'h00e00093);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
